alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Sequential, handshaked responder for the project ALU operation set. Accepts OP1/OP2/OPRN
//  on a START request, executes, and returns OUT/ZERO with a one-cycle DONE pulse.
//  MUL is a 32-step iterative shift-add. All other ops complete in one cycle.
//  Sits between the control unit (initiator) and the register file write-back path.
// PARAMETERS
//  DATA_W     `DATA_WIDTH (32)     operand/result width
//  OPRN_W     `ALU_OPRN_WIDTH (6)  opcode width
//  CNT_W      6                    MUL iteration counter width (>= clog2(DATA_W)+1)
// PORTS
//  CLK    in   1       single clock; all state updates on rising edge
//  RST    in   1       reset, synchronous, active-high
//  START  in   1       request; sampled only when BUSY=0
//  OP1    in   DATA_W  operand 1, captured when START accepted
//  OP2    in   DATA_W  operand 2, captured when START accepted
//  OPRN   in   OPRN_W  opcode, captured when START accepted
//  BUSY   out  1       operation in progress; START ignored while high
//  DONE   out  1       one-cycle pulse: OUT/ZERO valid for the accepted request
//  OUT    out  DATA_W  registered result; holds until next completion
//  ZERO   out  1       registered (OUT == 0)
// BEHAVIOUR
//  Reset (RST=1 at edge): state IDLE, OUT=0, ZERO=1, BUSY=0, DONE=0, counter=0; aborts any op.
//  States:
//   - IDLE: START=1 at edge k captures operands and sets BUSY=1.
//     Next state is MUL if OPRN=0x03, else EXEC.
//   - EXEC: edge k+1 writes OUT/ZERO and sets DONE=1, BUSY=0; next state IDLE. Latency 1.
//   - MUL: edges k+1..k+32 each run one shift-add step (LSB of multiplier).
//     Edge k+32 writes OUT/ZERO and sets DONE=1, BUSY=0; next state IDLE. Latency 32.
//  DONE is high for exactly one cycle after a completing edge, then low.
//  Back-to-back: START high in the DONE cycle (BUSY=0) is accepted at that edge.
//  START while BUSY=1 is ignored; it is not queued. Operand changes while BUSY have no effect.
//  Opcodes (unsigned, all results mod 2^DATA_W):
//   - 0x01 add: OP1+OP2
//   - 0x02 sub: OP1-OP2
//   - 0x03 mul: low DATA_W bits of OP1*OP2
//   - 0x04 shr: OP1>>OP2 (logical); 0x05 shl: OP1<<OP2. Full OP2 is the amount; >= DATA_W gives 0.
//   - 0x06 and: OP1&OP2; 0x07 or: OP1|OP2; 0x08 nor: ~(OP1|OP2)
//   - 0x09 slt: unsigned OP1<OP2 -> 1, else 0
//   - any other opcode: OUT=0, ZERO=1, 1-cycle latency (completes as EXEC)
//  RST asserted mid-MUL: next cycle is IDLE with reset values; no DONE for the aborted op.
//  RST and START high at the same edge: RST wins; request dropped.
// STRUCTURE
//  Shared in prj_definition.v:
//   - opcode constants `ALU_OPRN_ADD..`ALU_OPRN_SLT (0x01..0x09)
//   - state encodings `ALU_ST_IDLE/`ALU_ST_EXEC/`ALU_ST_MUL
//  Sub-module alu_mult_iter: multiplicand/multiplier/accumulator regs plus step counter.
//   Interface: load, step, product, last.
//  Parent holds the FSM, single-cycle datapath, and OUT/ZERO/DONE registers.
// TESTING
//  1. RST 2 cycles -> OUT=0, ZERO=1, BUSY=0, DONE=0.
//  2. ADD/SUB/logic, one request each:
//     - 15+3 -> 18, DONE at k+1
//     - 15-15 -> 0 with ZERO=1
//     - 15&5 -> 5; 15|3 -> 15; nor(15,3) -> 0xFFFFFFF0
//  3. Shifts and SLT:
//     - 15>>3 -> 1; 15<<5 -> 480; 15>>40 -> 0
//     - slt(3,15) -> 1; slt(1,1) -> 0, ZERO=1
//  4. MUL 15*3: BUSY high 32 cycles, DONE at k+32, OUT=45.
//     Also 0xFFFFFFFF*2 -> 0xFFFFFFFE.
//     START with new opcode during MUL is ignored; OUT is still 45.
//  5. Back-to-back: START held across DONE cycle (ADD then SUB 15-5).
//     -> two DONE pulses; OUT goes 18 then 10.
//  6. RST at cycle k+10 of a MUL -> IDLE next cycle, OUT=0, no DONE.
//     Unknown opcode 0x10 -> OUT=0, ZERO=1, DONE at k+1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: widths, opcodes, FSM states and single-cycle ALU function for alu_seq
package alu_seq_pkg;
  localparam int DATA_W = 32;
  localparam int OPRN_W = 6;
  localparam int CNT_W  = 6;
  localparam logic [OPRN_W-1:0] OP_ADD = 6'h01;
  localparam logic [OPRN_W-1:0] OP_SUB = 6'h02;
  localparam logic [OPRN_W-1:0] OP_MUL = 6'h03;
  localparam logic [OPRN_W-1:0] OP_SHR = 6'h04;
  localparam logic [OPRN_W-1:0] OP_SHL = 6'h05;
  localparam logic [OPRN_W-1:0] OP_AND = 6'h06;
  localparam logic [OPRN_W-1:0] OP_OR  = 6'h07;
  localparam logic [OPRN_W-1:0] OP_NOR = 6'h08;
  localparam logic [OPRN_W-1:0] OP_SLT = 6'h09;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL} state_t;
  // Shift amounts use the full operand, so anything >= DATA_W yields zero.
  function automatic logic [DATA_W-1:0] alu_exec(input logic [OPRN_W-1:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SHR:  return a >> b;
      OP_SHL:  return a << b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_NOR:  return ~(a | b);
      OP_SLT:  return DATA_W'(a < b);
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/alu_seq_mult.sv
// alu_mult_iter: iterative shift-add multiplier, one multiplier bit per step
module alu_mult_iter
  import alu_seq_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_product,
  output logic              o_last
);
  logic [DATA_W-1:0] r_mcand, r_mplier, r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_acc;
  // Product is the accumulator after the current step, so it is final on the last step.
  assign w_acc     = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_product = w_acc;
  assign o_last    = r_cnt == CNT_W'(DATA_W - 1);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_acc    <= w_acc;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU with 1-cycle ops and 32-step iterative MUL
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_op1,
  input  logic [DATA_W-1:0] i_op2,
  input  logic [OPRN_W-1:0] i_oprn,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_out,
  output logic              o_zero
);
  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_op1, r_op2, r_out;
  logic [OPRN_W-1:0] r_oprn;
  logic              r_done, r_zero;
  logic              w_accept, w_is_mul, w_last, w_finish;
  logic [DATA_W-1:0] w_product, w_result;
  assign w_accept = r_state == ST_IDLE && i_start;
  assign w_is_mul = i_oprn == OP_MUL;
  assign w_finish = r_state == ST_EXEC || (r_state == ST_MUL && w_last);
  assign w_result = r_state == ST_MUL ? w_product : alu_exec(r_oprn, r_op1, r_op2);
  always_comb begin
    w_next = r_state;
    w_next = r_state == ST_IDLE ? (i_start ? (w_is_mul ? ST_MUL : ST_EXEC) : ST_IDLE) :
             r_state == ST_EXEC ? ST_IDLE :
             (w_last ? ST_IDLE : ST_MUL);
  end
  alu_mult_iter u_mult (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_accept && w_is_mul),
    .i_step    (r_state == ST_MUL),
    .i_a       (i_op1),
    .i_b       (i_op2),
    .o_product (w_product),
    .o_last    (w_last)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_out   <= '0;
      r_zero  <= 1'b1;
      r_op1   <= '0;
      r_op2   <= '0;
      r_oprn  <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_finish;
      if (w_accept) begin
        r_op1  <= i_op1;
        r_op2  <= i_op2;
        r_oprn <= i_oprn;
      end
      if (w_finish) begin
        r_out  <= w_result;
        r_zero <= w_result == '0;
      end
    end
  end
  assign o_busy = r_state != ST_IDLE;
  assign o_done = r_done;
  assign o_out  = r_out;
  assign o_zero = r_zero;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: randomized and directed checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op1 = '0, op2 = '0;
  logic [5:0]  oprn = '0;
  logic        busy, done, zero;
  logic [31:0] out;
  int checks = 0;
  int errors = 0;

  alu_seq dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op1(op1), .i_op2(op2), .i_oprn(oprn),
    .o_busy(busy), .o_done(done), .o_out(out), .o_zero(zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      6'h01: return a + b;
      6'h02: return a - b;
      6'h03: return p[31:0];
      6'h04: return (b >= 32) ? 32'd0 : a >> b[4:0];
      6'h05: return (b >= 32) ? 32'd0 : a << b[4:0];
      6'h06: return a & b;
      6'h07: return a | b;
      6'h08: return ~(a | b);
      6'h09: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    int n, lat;
    logic [31:0] exp;
    exp = model(op, a, b);
    lat = (op == 6'h03) ? 32 : 1;
    @(negedge clk);
    op1 = a; op2 = b; oprn = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_accept got %b want 1", name, busy); end
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
      if (done !== 1'b1 && busy !== 1'b1) begin errors++; $display("FAIL %s busy_dropped at %0d", name, n); end
    end
    checks++;
    if (n != lat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, n, lat); end
    checks++;
    if (out !== exp || zero !== (exp == 0)) begin
      errors++; $display("FAIL %s result got %h/%b want %h/%b", name, out, zero, exp, exp == 0);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_done got %b want 0", name, busy); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done_pulse got %b want 0", name, done); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    checks++;
    if (out !== 32'd0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset got out=%h zero=%b busy=%b done=%b want 0/1/0/0", out, zero, busy, done);
    end
  endtask

  task automatic test_arith_logic();
    do_op(6'h01, 15, 3, "add");
    do_op(6'h02, 15, 15, "sub_zero");
    do_op(6'h06, 15, 5, "and");
    do_op(6'h07, 15, 3, "or");
    do_op(6'h08, 15, 3, "nor");
  endtask

  task automatic test_shift_slt();
    do_op(6'h04, 15, 3, "shr");
    do_op(6'h05, 15, 5, "shl");
    do_op(6'h04, 15, 40, "shr_big");
    do_op(6'h05, 32'hFFFF_FFFF, 32, "shl_32");
    do_op(6'h09, 3, 15, "slt_true");
    do_op(6'h09, 1, 1, "slt_eq");
  endtask

  task automatic test_mul();
    int n;
    do_op(6'h03, 32'hFFFF_FFFF, 2, "mul_wrap");
    @(negedge clk);
    op1 = 15; op2 = 3; oprn = 6'h03; start = 1'b1;
    @(posedge clk); #1;
    oprn = 6'h01; op1 = 100; op2 = 100;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (n == 10) start = 1'b0;
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != 32 || out !== 32'd45) begin errors++; $display("FAIL mul_ignore got lat=%0d out=%0d want 32/45", n, out); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mul_not_queued got busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    op1 = 15; op2 = 3; oprn = 6'h01; start = 1'b1;
    @(posedge clk); #1;
    op2 = 5; oprn = 6'h02;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || out !== 32'd18 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_first got done=%b out=%0d busy=%b want 1/18/0", done, out, busy);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got done=%b busy=%b want 0/1", done, busy); end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || out !== 32'd10) begin errors++; $display("FAIL b2b_second got done=%b out=%0d want 1/10", done, out); end
  endtask

  task automatic test_reset_abort();
    int seen;
    @(negedge clk);
    op1 = 7; op2 = 9; oprn = 6'h03; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || out !== 32'd0 || zero !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL abort_state got busy=%b out=%h zero=%b done=%b want 0/0/1/0", busy, out, zero, done);
    end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done === 1'b1) seen++; end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", seen); end
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op1 = 1; op2 = 2; oprn = 6'h01;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    seen = 0;
    repeat (5) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) seen++; end
    checks++;
    if (seen != 0 || out !== 32'd0) begin errors++; $display("FAIL rst_start got activity=%0d out=%h want 0/0", seen, out); end
    do_op(6'h10, 32'h1234, 32'h5678, "unknown_op");
  endtask

  task automatic test_random();
    logic [5:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 6'($urandom_range(1, 10));
      if (op == 6'h0A) op = 6'h2A;
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 40));
      do_op(op, a, b, "random");
    end
  endtask

  initial begin
    test_reset();
    test_arith_logic();
    test_shift_slt();
    test_mul();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
